imem_pipelined: RTL and testbench

//  Parametrised instruction memory, successor of the single-port IMEM. Adds a

---
 rtl/imem_pipelined.sv | 146 ++++++++++++++
 tb/tb_imem_pipelined.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_pipelined.sv
// Instruction memory with a streaming valid/ready loader, a fully pipelined fetch
// port of configurable latency, and misaligned/out-of-range fault reporting.
module imem_pipelined #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DEPTH  = 256,
    parameter int unsigned RD_LAT = 1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       load_start,
    input  logic [$clog2(DEPTH)-1:0]   load_base,
    input  logic                       load_valid,
    input  logic [DATA_W-1:0]          load_data,
    input  logic                       load_last,
    output logic                       load_ready,
    output logic                       load_done,
    output logic                       load_wrap,
    input  logic                       fetch_req,
    input  logic [ADDR_W-1:0]          fetch_addr,
    output logic                       fetch_ready,
    output logic                       fetch_valid,
    output logic [DATA_W-1:0]          fetch_data,
    output logic                       fetch_err,
    output logic                       busy
);

    localparam int unsigned IDX_W = $clog2(DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DRAIN,
        ST_LOAD,
        ST_DONE
    } state_t;

    state_t                         state_q, state_d;
    logic [IDX_W-1:0]               ptr_q, ptr_d;
    logic                           wrap_q, wrap_d;
    logic                           mem_we_c;
    logic [DATA_W-1:0]              mem [DEPTH];

    logic [RD_LAT-1:0]              pv_q, pv_d;
    logic [RD_LAT-1:0]              pe_q, pe_d;
    logic [RD_LAT-1:0][DATA_W-1:0]  pd_q, pd_d;

    logic                           pipe_empty_c;
    logic                           fetch_acc_c;
    logic [ADDR_W-1:0]              word_idx_c;
    logic                           addr_err_c;
    logic [DATA_W-1:0]              rd_data_c;

    assign pipe_empty_c = ~|pv_q;
    assign fetch_ready  = (state_q == ST_IDLE) && !load_start;
    assign fetch_acc_c  = fetch_req && fetch_ready;
    assign word_idx_c   = fetch_addr >> 2;
    assign addr_err_c   = (|fetch_addr[1:0]) || (word_idx_c >= ADDR_W'(DEPTH));
    assign rd_data_c    = addr_err_c ? '0 : mem[word_idx_c[IDX_W-1:0]];

    // Loader session control
    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        wrap_d   = wrap_q;
        mem_we_c = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (load_start) begin
                    ptr_d   = load_base;
                    wrap_d  = 1'b0;
                    state_d = pipe_empty_c ? ST_LOAD : ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (pipe_empty_c) state_d = ST_LOAD;
            end
            ST_LOAD: begin
                if (load_valid) begin
                    mem_we_c = 1'b1;
                    ptr_d    = ptr_q + IDX_W'(1);
                    if (ptr_q == IDX_W'(DEPTH - 1)) wrap_d = 1'b1;
                    if (load_last) state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            wrap_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            wrap_q  <= wrap_d;
        end
    end

    // Storage array is deliberately not reset
    always_ff @(posedge clk) begin
        if (mem_we_c) mem[ptr_q] <= load_data;
    end

    // Read data captured at acceptance, then delayed to the configured latency
    always_comb begin
        pv_d    = '0;
        pe_d    = '0;
        pd_d    = '0;
        pv_d[0] = fetch_acc_c;
        pe_d[0] = fetch_acc_c && addr_err_c;
        pd_d[0] = fetch_acc_c ? rd_data_c : '0;
        for (int unsigned k = 1; k < RD_LAT; k++) begin
            pv_d[k] = pv_q[k-1];
            pe_d[k] = pe_q[k-1];
            pd_d[k] = pd_q[k-1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pv_q <= '0;
            pe_q <= '0;
            pd_q <= '0;
        end else begin
            pv_q <= pv_d;
            pe_q <= pe_d;
            pd_q <= pd_d;
        end
    end

    assign fetch_valid = pv_q[RD_LAT-1];
    assign fetch_err   = pe_q[RD_LAT-1];
    assign fetch_data  = pd_q[RD_LAT-1];
    assign load_ready  = (state_q == ST_LOAD);
    assign load_done   = (state_q == ST_DONE);
    assign load_wrap   = wrap_q;
    assign busy        = (state_q != ST_IDLE);

endmodule

// File: tb/tb_imem_pipelined.sv
// Bench for imem_pipelined: directed scenarios plus random traffic, every cycle
// compared against a cycle-level reference model of the memory and loader.
module tb_imem_pipelined;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DEPTH  = 16;
    localparam int unsigned RD_LAT = 3;
    localparam int unsigned IDX_W  = 4;

    localparam int S_IDLE  = 0;
    localparam int S_DRAIN = 1;
    localparam int S_LOAD  = 2;
    localparam int S_DONE  = 3;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              load_start;
    logic [IDX_W-1:0]  load_base;
    logic              load_valid;
    logic [DATA_W-1:0] load_data;
    logic              load_last;
    logic              load_ready;
    logic              load_done;
    logic              load_wrap;
    logic              fetch_req;
    logic [ADDR_W-1:0] fetch_addr;
    logic              fetch_ready;
    logic              fetch_valid;
    logic [DATA_W-1:0] fetch_data;
    logic              fetch_err;
    logic              busy;

    imem_pipelined #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .RD_LAT(RD_LAT)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .load_start(load_start), .load_base(load_base), .load_valid(load_valid),
        .load_data(load_data), .load_last(load_last), .load_ready(load_ready),
        .load_done(load_done), .load_wrap(load_wrap),
        .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_ready(fetch_ready),
        .fetch_valid(fetch_valid), .fetch_data(fetch_data), .fetch_err(fetch_err),
        .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          due;
        logic        err;
        logic [31:0] data;
    } resp_t;

    int          checks   = 0;
    int          failures = 0;
    resp_t       rq[$];
    logic [31:0] mm[DEPTH];
    int          m_st;
    int          m_ptr;
    logic        m_wrap;
    int          cyc = 0;
    logic [31:0] beats[DEPTH];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s cycle=%0d observed=0x%08h expected=0x%08h", tag, cyc, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_st   = S_IDLE;
        m_ptr  = 0;
        m_wrap = 1'b0;
        rq.delete();
    endtask

    task automatic idle_inputs();
        load_start = 1'b0;
        load_valid = 1'b0;
        load_last  = 1'b0;
        fetch_req  = 1'b0;
    endtask

    // Compare all outputs for the current cycle, then advance the model across the edge
    task automatic step();
        logic  ev, ee;
        logic [31:0] ed;
        bit    inflight;
        resp_t r;
        #1;
        ev = 1'b0; ee = 1'b0; ed = '0;
        if (rq.size() > 0 && rq[0].due == cyc) begin
            ev = 1'b1; ee = rq[0].err; ed = rq[0].data;
        end
        chk("fetch_valid", 32'(fetch_valid), 32'(ev));
        chk("fetch_err",   32'(fetch_err),   32'(ee));
        chk("fetch_data",  fetch_data,       ed);
        chk("fetch_ready", 32'(fetch_ready), 32'(m_st == S_IDLE && !load_start));
        chk("load_ready",  32'(load_ready),  32'(m_st == S_LOAD));
        chk("load_done",   32'(load_done),   32'(m_st == S_DONE));
        chk("load_wrap",   32'(load_wrap),   32'(m_wrap));
        chk("busy",        32'(busy),        32'(m_st != S_IDLE));
        if (rst_n) begin
            inflight = rq.size() > 0;
            if (ev) void'(rq.pop_front());
            case (m_st)
                S_IDLE: begin
                    if (load_start) begin
                        m_ptr  = int'(load_base);
                        m_wrap = 1'b0;
                        m_st   = inflight ? S_DRAIN : S_LOAD;
                    end else if (fetch_req) begin
                        r.due  = cyc + int'(RD_LAT);
                        r.err  = (fetch_addr % 4 != 0) || (fetch_addr / 4 >= DEPTH);
                        r.data = '0;
                        if (!r.err) r.data = mm[fetch_addr / 4];
                        rq.push_back(r);
                    end
                end
                S_DRAIN: if (!inflight) m_st = S_LOAD;
                S_LOAD: begin
                    if (load_valid) begin
                        mm[m_ptr] = load_data;
                        if (m_ptr == int'(DEPTH) - 1) m_wrap = 1'b1;
                        m_ptr = (m_ptr + 1) % int'(DEPTH);
                        if (load_last) m_st = S_DONE;
                    end
                end
                default: m_st = S_IDLE;
            endcase
        end
        cyc++;
        @(negedge clk);
    endtask

    // One load session of n beats from beats[]; optionally a fetch collides with the start
    task automatic do_load(input int base, input int n, input bit gaps,
                           input bit with_fetch, input int abort_after);
        int i = 0;
        int guard = 0;
        bit acc;
        load_start = 1'b1;
        load_base  = IDX_W'(base);
        fetch_req  = with_fetch;
        fetch_addr = 32'h8;
        step();
        idle_inputs();
        while (i < n && i != abort_after && guard < 200) begin
            load_valid = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
            load_data  = beats[i];
            load_last  = (i == n - 1);
            acc = (m_st == S_LOAD) && load_valid;
            step();
            if (acc) i++;
            guard++;
        end
        idle_inputs();
        chk("beats_accepted", 32'(i), 32'(abort_after >= 0 ? abort_after : n));
        if (abort_after < 0) begin
            step();
            step();
        end
    endtask

    task automatic fetch_seq(input logic [31:0] base_addr, input int n);
        for (int i = 0; i < n; i++) begin
            fetch_req  = 1'b1;
            fetch_addr = base_addr + 32'(i * 4);
            step();
        end
        fetch_req = 1'b0;
    endtask

    task automatic fetch_one(input logic [31:0] a);
        fetch_req  = 1'b1;
        fetch_addr = a;
        step();
        fetch_req = 1'b0;
        repeat (RD_LAT + 1) step();
    endtask

    function automatic logic [31:0] rand_addr();
        case ($urandom_range(0, 5))
            0:       return 32'($urandom_range(0, DEPTH - 1) * 4 + $urandom_range(1, 3));
            1:       return 32'(DEPTH * 4 + $urandom_range(0, 255) * 4);
            2:       return $urandom;
            default: return 32'($urandom_range(0, DEPTH - 1) * 4);
        endcase
    endfunction

    initial begin
        rst_n      = 1'b0;
        load_base  = '0;
        load_data  = '0;
        fetch_addr = '0;
        idle_inputs();
        model_reset();
        @(negedge clk);
        step();
        step();
        rst_n = 1'b1;
        step();

        // Basic load then fetch back
        for (int i = 0; i < 4; i++) beats[i] = 32'h1111_1111 * 32'(i + 1);
        do_load(0, 4, 1'b0, 1'b0, -1);
        fetch_seq(32'h0, 4);
        repeat (RD_LAT + 1) step();

        // Fill the rest so every word is defined
        for (int i = 0; i < int'(DEPTH); i++) beats[i] = $urandom;
        do_load(4, int'(DEPTH) - 4, 1'b1, 1'b0, -1);

        // Back-to-back stream
        fetch_seq(32'h0, 8);
        repeat (RD_LAT + 1) step();

        // Faults and boundaries
        fetch_one(32'h2);
        fetch_one(32'(DEPTH * 4));
        fetch_one(32'(DEPTH * 4 - 4));
        fetch_one(32'h0);

        // Wrapping load
        for (int i = 0; i < 4; i++) beats[i] = 32'hC0DE_0000 + 32'(i);
        do_load(int'(DEPTH) - 2, 4, 1'b0, 1'b0, -1);
        fetch_seq(32'(DEPTH * 4 - 8), 2);
        fetch_seq(32'h0, 2);
        repeat (RD_LAT + 1) step();

        // Start collides with a fetch while two are in flight
        fetch_seq(32'h0, 2);
        for (int i = 0; i < 2; i++) beats[i] = 32'h5A5A_0000 + 32'(i);
        do_load(2, 2, 1'b0, 1'b1, -1);
        fetch_seq(32'h8, 2);
        repeat (RD_LAT + 1) step();

        // Reset in the middle of a session
        for (int i = 0; i < 4; i++) beats[i] = 32'hA0A0_0000 + 32'(i);
        do_load(8, 4, 1'b0, 1'b0, 2);
        rst_n = 1'b0;
        model_reset();
        step();
        step();
        rst_n = 1'b1;
        step();
        fetch_seq(32'h20, 4);
        repeat (RD_LAT + 1) step();

        // Random traffic
        for (int t = 0; t < 1500; t++) begin
            idle_inputs();
            fetch_addr = rand_addr();
            load_data  = $urandom;
            case (m_st)
                S_IDLE: begin
                    fetch_req = ($urandom_range(0, 2) != 0);
                    if ($urandom_range(0, 24) == 0) begin
                        load_start = 1'b1;
                        load_base  = IDX_W'($urandom_range(0, DEPTH - 1));
                    end
                end
                S_LOAD: begin
                    load_valid = ($urandom_range(0, 3) != 0);
                    load_last  = ($urandom_range(0, 4) == 0);
                    load_start = ($urandom_range(0, 7) == 0);
                end
                default: begin
                    fetch_req  = ($urandom_range(0, 1) != 0);
                    load_start = ($urandom_range(0, 3) == 0);
                    load_valid = ($urandom_range(0, 1) != 0);
                end
            endcase
            step();
        end
        idle_inputs();
        repeat (RD_LAT + 8) step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
